// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - IF/ID register and front-end advance/hold/flush sequencer.
// Optional stall/flush performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        if_valid,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        mem_busy,
  output logic        pc_en,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_valid,
  output logic        id_ex_en,
  output logic        id_ex_flush,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [1:0]  ST_RUN      = 2'd0;
  localparam logic [1:0]  ST_STALL_LU = 2'd1;
  localparam logic [1:0]  ST_WAIT_MEM = 2'd2;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  logic [1:0] state, next_state;
  logic       uses_rs1, uses_rs2, load_use;
  logic       load_nop, load_fetch, count_stall, count_flush;

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (id_instr[6:0])
      7'b0110011, 7'b0100011, 7'b1100011: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: uses_rs1 = 1'b1;
      default: ;
    endcase
  end

  // The one-cycle stall has already put the bubble into EX; never re-stall from STALL_LU.
  assign load_use = id_valid && ex_mem_read && (ex_rd != 5'd0) && (state != ST_STALL_LU) &&
                    ((uses_rs1 && (ex_rd == id_instr[19:15])) ||
                     (uses_rs2 && (ex_rd == id_instr[24:20])));

  always_comb begin
    pc_en       = 1'b0;
    id_ex_en    = 1'b0;
    id_ex_flush = 1'b0;
    next_state  = ST_RUN;
    load_nop    = 1'b0;
    load_fetch  = 1'b0;
    count_stall = 1'b0;
    count_flush = 1'b0;
    if (rst) begin
      id_ex_flush = 1'b1;
    end else if (mem_busy) begin
      next_state  = ST_WAIT_MEM;
      count_stall = 1'b1;
    end else if (ex_branch_taken) begin
      pc_en       = 1'b1;
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b1;
      load_nop    = 1'b1;
      count_flush = 1'b1;
    end else if (load_use) begin
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b1;
      next_state  = ST_STALL_LU;
      count_stall = 1'b1;
    end else if (!if_valid) begin
      id_ex_en = 1'b1;
      load_nop = 1'b1;
    end else begin
      pc_en      = 1'b1;
      id_ex_en   = 1'b1;
      load_fetch = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      id_instr <= NOP;
      id_pc    <= 32'd0;
      id_valid <= 1'b0;
    end else begin
      state <= next_state;
      if (load_nop) begin
        id_instr <= NOP;
        id_valid <= 1'b0;
      end else if (load_fetch) begin
        id_instr <= if_instr;
        id_pc    <= if_pc;
        id_valid <= 1'b1;
      end
    end
  end

  assign ctrl_state = state;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 32'd0;
      flush_q <= 32'd0;
    end else begin
      if (count_stall) stall_q <= stall_q + 32'd1;
      if (count_flush) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  logic unused_cnt;
  assign unused_cnt = count_stall ^ count_flush;
  assign stall_cnt  = 32'd0;
  assign flush_cnt  = 32'd0;
`endif

endmodule
